// File: rtl/mio_reg_master.sv
// Register-access initiator for the MIO config block: turns single read/write
// commands into emesh request packets and returns readback data or a timeout.
module mio_reg_master #(
  parameter int              AW       = 32,
  parameter int              PW       = 104,
  parameter logic [AW-1:0]   SRCADDR  = '0,
  parameter logic [4:0]      CTRLMODE = 5'h0,
  parameter int              TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          reset,
  // host command side
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [31:0]   cmd_data,
  output logic          rsp_valid,
  output logic [31:0]   rsp_data,
  output logic          rsp_error,
  // emesh request / readback side
  output logic          access_out,
  output logic [PW-1:0] packet_out,
  input  logic          wait_in,
  input  logic          access_in,
  input  logic [PW-1:0] packet_in,
  output logic          wait_out,
  output logic          stray
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_SEND      = 2'd1;
  localparam logic [1:0] S_READ_WAIT = 2'd2;
  localparam logic [1:0] S_RESP      = 2'd3;

  logic [1:0]    r_state;
  logic [15:0]   r_timer;
  logic          r_access_out;
  logic [PW-1:0] r_packet_out;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_data;
  logic          r_rsp_error;
  logic          r_stray;

  logic [PW-1:0] w_req_pkt;
  logic [31:0]   w_req_data;
  logic [31:0]   w_rd_data;
  logic [16:0]   w_timer_inc;
  logic          w_timeout;
  logic          w_unused_pkt;

  // Read requests carry no payload, so their data field is zeroed.
  assign w_req_data = cmd_write ? cmd_data : 32'h0;
  assign w_req_pkt  = {SRCADDR, w_req_data, cmd_addr, CTRLMODE, 2'b10, cmd_write};
  assign w_rd_data  = packet_in[AW+39:AW+8];

  // Expiry is judged on the incremented count so the response lands exactly
  // TIMEOUT cycles after the transfer cycle.
  assign w_timer_inc = {1'b0, r_timer} + 17'd1;
  assign w_timeout   = (w_timer_inc >= 17'(TIMEOUT - 1));

  assign w_unused_pkt = ^{packet_in[AW+7:0], packet_in[PW-1:AW+40]};

  assign cmd_ready  = (r_state == S_IDLE) & ~reset;
  assign wait_out   = 1'b0;
  assign access_out = r_access_out;
  assign packet_out = r_packet_out;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_error  = r_rsp_error;
  assign stray      = r_stray;

  // NOTE: every register, including the packet holding register, is reset so
  // a mid-transaction reset leaves no stale request on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_access_out <= 1'b0;
      r_packet_out <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_error  <= 1'b0;
      r_stray      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every branch sees pre-edge state.
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_packet_out <= w_req_pkt;
            r_access_out <= 1'b1;
            r_state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (!wait_in) begin
            r_access_out <= 1'b0;
            if (r_packet_out[0]) begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_error <= 1'b0;
              r_state     <= S_RESP;
            end else begin
              r_timer <= '0;
              r_state <= S_READ_WAIT;
            end
          end
        end
        S_READ_WAIT: begin
          r_timer <= w_timer_inc[15:0];
          // A readback coinciding with expiry still counts as a good response.
          if (access_in) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd_data;
            r_rsp_error <= 1'b0;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase

      if (access_in && (r_state != S_READ_WAIT)) begin
        r_stray <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mio_reg_master.sv
// Scoreboard bench for mio_reg_master: directed commands push expected packets
// and responses; a negedge monitor pops and compares what the DUT presents.
module tb_mio_reg_master;

  localparam int AW = 32;
  localparam int PW = 104;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_data;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          rsp_error;
  logic          access_out;
  logic [PW-1:0] packet_out;
  logic          wait_in;
  logic          access_in;
  logic [PW-1:0] packet_in;
  logic          wait_out;
  logic          stray;

  mio_reg_master #(
    .AW(AW), .PW(PW), .SRCADDR(32'h0000_0ABC), .CTRLMODE(5'h03), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .access_out(access_out), .packet_out(packet_out), .wait_in(wait_in),
    .access_in(access_in), .packet_in(packet_in), .wait_out(wait_out),
    .stray(stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc, xfer_cyc, rsp_cyc;
  int n_access = 0, n_xfers = 0, n_rsp = 0, n_ready_busy = 0;

  logic [PW-1:0] exp_pkt[$];
  rsp_t          exp_rsp[$];
  logic          prev_hold = 1'b0;
  logic [PW-1:0] prev_pkt  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: transfers pop the packet queue, responses pop the response queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (access_out) begin
        n_access++;
        if (cmd_ready) n_ready_busy++;
        if (prev_hold) check("pkt_stable", packet_out, prev_pkt);
        if (!wait_in) begin
          n_xfers++;
          xfer_cyc = cyc;
          if (exp_pkt.size() == 0) check("unexpected_xfer", 1, 0);
          else check("pkt", packet_out, exp_pkt.pop_front());
        end
      end
      prev_hold = access_out && wait_in;
      prev_pkt  = packet_out;
      if (rsp_valid) begin
        rsp_t e;
        n_rsp++;
        rsp_cyc = cyc;
        if (exp_rsp.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          e = exp_rsp.pop_front();
          check("rsp_error", rsp_error, e.err);
          check("rsp_data", rsp_data, e.data);
        end
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data,
                       input logic [PW-1:0] pkt, input logic err, input logic [31:0] rdata);
    rsp_t r;
    int i;
    @(negedge clk);
    for (i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_data  = data;
    acc_cyc   = cyc;
    r.err = err;
    r.data = rdata;
    exp_pkt.push_back(pkt);
    exp_rsp.push_back(r);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int prev);
    for (int i = 0; i < 200 && n_rsp == prev; i++) @(posedge clk);
    check("rsp_seen", (n_rsp != prev), 1);
  endtask

  task automatic wait_xfer(input int prev);
    for (int i = 0; i < 200 && n_xfers == prev; i++) @(posedge clk);
    check("xfer_seen", (n_xfers != prev), 1);
  endtask

  // Drive a one-cycle readback packet in cycle 'at' (data in the payload field,
  // junk elsewhere to prove only the data slice is used).
  task automatic drive_readback(input int at, input logic [31:0] data);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < at);
    access_in = 1'b1;
    packet_in = {32'hDEAD_0000, data, 32'h1111_2222, 8'h5A};
    @(posedge clk);
    #1;
    access_in = 1'b0;
    packet_in = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, x0, r0, b0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
    wait_in = 1'b0; access_in = 1'b0; packet_in = '0;

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_outputs", {access_out, rsp_valid, rsp_error, stray, wait_out}, 5'b0);
    check("rst_packet", packet_out, 0);
    check("rst_rsp_data", rsp_data, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    // Write, no pushback
    a0 = n_access; r0 = n_rsp;
    issue(1'b1, 32'h4, 32'h1234_5678, 104'h00000ABC_12345678_00000004_1D, 1'b0, 32'h0);
    wait_rsp(r0);
    check("wr_xfer_lat", xfer_cyc - acc_cyc, 1);
    check("wr_rsp_lat", rsp_cyc - acc_cyc, 2);
    check("wr_access_cycles", n_access - a0, 1);

    // Write with 5 cycles of pushback
    @(posedge clk); #1 wait_in = 1'b1;
    a0 = n_access; x0 = n_xfers; r0 = n_rsp; b0 = n_ready_busy;
    issue(1'b1, 32'h10, 32'hA5A5_0001, 104'h00000ABC_A5A50001_00000010_1D, 1'b0, 32'h0);
    repeat (5) @(posedge clk);
    #1 wait_in = 1'b0;
    wait_rsp(r0);
    check("wait_access_cycles", n_access - a0, 6);
    check("wait_single_xfer", n_xfers - x0, 1);
    check("wait_ready_low", n_ready_busy - b0, 0);
    check("wait_rsp_lat", rsp_cyc - acc_cyc, 7);

    // Read with readback 3 cycles after transfer
    x0 = n_xfers; r0 = n_rsp;
    issue(1'b0, 32'h8, 32'h0, 104'h00000ABC_00000000_00000008_1C, 1'b0, 32'hCAFE_F00D);
    wait_xfer(x0);
    drive_readback(xfer_cyc + 3, 32'hCAFE_F00D);
    wait_rsp(r0);
    check("rd_rsp_lat", rsp_cyc - xfer_cyc, 4);
    repeat (3) @(negedge clk);
    check("rd_data_hold", rsp_data, 32'hCAFE_F00D);
    check("rd_single_pulse", rsp_valid, 0);

    // Read with no readback: timeout
    x0 = n_xfers; r0 = n_rsp;
    issue(1'b0, 32'h20, 32'h0, 104'h00000ABC_00000000_00000020_1C, 1'b1, 32'h0);
    wait_xfer(x0);
    wait_rsp(r0);
    check("timeout_lat", rsp_cyc - xfer_cyc, 16);
    @(negedge clk);
    check("stray_before", stray, 0);
    drive_readback(cyc + 2, 32'h0BAD_0BAD);
    @(negedge clk);
    check("stray_after", stray, 1);

    // Readback in the same cycle the timer expires
    x0 = n_xfers; r0 = n_rsp;
    issue(1'b0, 32'h24, 32'h0, 104'h00000ABC_00000000_00000024_1C, 1'b0, 32'h600D_BEEF);
    wait_xfer(x0);
    drive_readback(xfer_cyc + 15, 32'h600D_BEEF);
    wait_rsp(r0);
    check("collide_lat", rsp_cyc - xfer_cyc, 16);

    // Reset during READ_WAIT
    x0 = n_xfers;
    issue(1'b0, 32'h30, 32'h0, 104'h00000ABC_00000000_00000030_1C, 1'b0, 32'h0);
    wait_xfer(x0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    exp_rsp.delete();
    r0 = n_rsp;
    @(negedge clk);
    check("midrst_outputs", {access_out, rsp_valid, rsp_error, stray, cmd_ready}, 5'b0);
    check("midrst_packet", packet_out, 0);
    check("midrst_rsp_data", rsp_data, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", cmd_ready, 1);
    repeat (25) @(posedge clk);
    check("midrst_no_rsp", n_rsp - r0, 0);
    check("midrst_stray", stray, 0);

    check("rsp_queue_empty", exp_rsp.size(), 0);
    check("pkt_queue_empty", exp_pkt.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
